// File: rtl/complex_mult_pkg.sv
// Shared definitions for the complex multiplier datapath and its accumulate stage.
// Holds the default widths, their derivation helpers and the stage state encoding.
package complex_mult_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF  = 4;

    // Each product component needs two operand widths plus one bit for the re/im sum.
    function automatic int res_width(input int data_width);
        return 2 * data_width + 1;
    endfunction

    // CNT_WIDTH guard bits let 2^CNT_WIDTH full-scale products sum without overflow.
    function automatic int acc_width(input int r_width, input int c_width);
        return r_width + c_width;
    endfunction

    localparam int RES_WIDTH_DEF = res_width(DATA_WIDTH_DEF);
    localparam int ACC_WIDTH_DEF = acc_width(RES_WIDTH_DEF, CNT_WIDTH_DEF);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } acc_state_e;

endpackage

// File: rtl/complex_acc_lane.sv
// One signed component (re or im) of the accumulator: loads or adds a sign-extended beat.
// The next value is also exported so the top can capture the final sum on the last beat.
module complex_acc_lane
    import complex_mult_pkg::*;
#(
    parameter int RES_WIDTH = RES_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 load,
    input  logic [RES_WIDTH-1:0] din,
    output logic [ACC_WIDTH-1:0] acc,
    output logic [ACC_WIDTH-1:0] acc_nxt
);

    logic [ACC_WIDTH-1:0] ext_s;
    logic [ACC_WIDTH-1:0] nxt_s;
    logic [ACC_WIDTH-1:0] acc_r;

    // Sign-extend the beat and either start a new sum or add to the running one
    always_comb begin
        ext_s = {{(ACC_WIDTH-RES_WIDTH){din[RES_WIDTH-1]}}, din};
        if (load) begin
            nxt_s = ext_s;
        end else begin
            nxt_s = acc_r + ext_s;
        end
    end

    // Accumulator register; it only moves on an accepted beat so idle data never reaches it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_r <= {ACC_WIDTH{1'b0}};
        end else if (clr) begin
            acc_r <= {ACC_WIDTH{1'b0}};
        end else if (en) begin
            acc_r <= nxt_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc     = acc_r;
    assign acc_nxt = nxt_s;

endmodule

// File: rtl/complex_acc_stage.sv
// Accumulates acc_len consecutive complex products into a widened complex dot product.
// Results arrive on a valid/ready input and the sum leaves on a registered valid/ready output.
module complex_acc_stage
    import complex_mult_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RES_WIDTH  = res_width(DATA_WIDTH),
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int ACC_WIDTH  = acc_width(RES_WIDTH, CNT_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   sw_rst,
    input  logic [CNT_WIDTH-1:0]   acc_len,
    input  logic                   res_val,
    output logic                   res_ready,
    input  logic [2*RES_WIDTH-1:0] res_data,
    output logic                   acc_val,
    input  logic                   acc_ready,
    output logic [2*ACC_WIDTH-1:0] acc_data,
    output logic                   busy
);

    acc_state_e             state_r;
    acc_state_e             state_nxt_s;

    logic [CNT_WIDTH-1:0]   cnt_r;
    logic [CNT_WIDTH-1:0]   cnt_nxt_s;
    logic [CNT_WIDTH-1:0]   len_q_r;
    logic [CNT_WIDTH-1:0]   len_q_nxt_s;
    logic [CNT_WIDTH-1:0]   len_eff_s;
    logic [CNT_WIDTH-1:0]   len_m1_s;

    logic                   res_ready_r;
    logic                   res_ready_nxt_s;
    logic                   acc_val_r;
    logic                   acc_val_nxt_s;
    logic                   busy_r;
    logic                   busy_nxt_s;
    logic [2*ACC_WIDTH-1:0] acc_data_r;
    logic [2*ACC_WIDTH-1:0] acc_data_nxt_s;

    logic                   beat_s;
    logic                   first_s;
    logic                   last_s;

    logic [RES_WIDTH-1:0]   res_re_s;
    logic [RES_WIDTH-1:0]   res_im_s;
    logic [ACC_WIDTH-1:0]   acc_re_s;
    logic [ACC_WIDTH-1:0]   acc_im_s;
    logic [ACC_WIDTH-1:0]   acc_re_nxt_s;
    logic [ACC_WIDTH-1:0]   acc_im_nxt_s;

    assign res_re_s = res_data[2*RES_WIDTH-1:RES_WIDTH];
    assign res_im_s = res_data[RES_WIDTH-1:0];

    // Beat qualification; the length in force is acc_len on the first beat, len_q_r afterwards
    always_comb begin
        beat_s  = res_val & res_ready_r;
        first_s = (cnt_r == {CNT_WIDTH{1'b0}});
        if (first_s) begin
            len_eff_s = acc_len;
        end else begin
            len_eff_s = len_q_r;
        end
        // A length of zero wraps to all-ones here, giving 2^CNT_WIDTH beats
        len_m1_s = len_eff_s - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        last_s   = beat_s & (cnt_r == len_m1_s);
    end

    complex_acc_lane #(
        .RES_WIDTH (RES_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_lane_re (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (sw_rst),
        .en      (beat_s),
        .load    (first_s),
        .din     (res_re_s),
        .acc     (acc_re_s),
        .acc_nxt (acc_re_nxt_s)
    );

    complex_acc_lane #(
        .RES_WIDTH (RES_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_lane_im (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (sw_rst),
        .en      (beat_s),
        .load    (first_s),
        .din     (res_im_s),
        .acc     (acc_im_s),
        .acc_nxt (acc_im_nxt_s)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a software reset always lands in S_ACCUM
    always_comb begin
        state_nxt_s = state_r;
        if (sw_rst) begin
            state_nxt_s = S_ACCUM;
        end else begin
            case (state_r)
                S_IDLE:  state_nxt_s = S_ACCUM;
                S_ACCUM: begin
                    if (last_s) begin
                        state_nxt_s = S_OUT;
                    end else begin
                        state_nxt_s = S_ACCUM;
                    end
                end
                S_OUT: begin
                    if (acc_ready) begin
                        state_nxt_s = S_ACCUM;
                    end else begin
                        state_nxt_s = S_OUT;
                    end
                end
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // Output and datapath next values, all registered below
    always_comb begin
        cnt_nxt_s       = cnt_r;
        len_q_nxt_s     = len_q_r;
        acc_data_nxt_s  = acc_data_r;
        res_ready_nxt_s = (state_nxt_s == S_ACCUM);
        acc_val_nxt_s   = (state_nxt_s == S_OUT);
        if (sw_rst) begin
            cnt_nxt_s      = {CNT_WIDTH{1'b0}};
            len_q_nxt_s    = {CNT_WIDTH{1'b0}};
            acc_data_nxt_s = {(2*ACC_WIDTH){1'b0}};
        end else if (beat_s) begin
            if (first_s) begin
                len_q_nxt_s = acc_len;
            end else begin
                len_q_nxt_s = len_q_r;
            end
            if (last_s) begin
                cnt_nxt_s      = {CNT_WIDTH{1'b0}};
                acc_data_nxt_s = {acc_re_nxt_s, acc_im_nxt_s};
            end else begin
                cnt_nxt_s = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
        busy_nxt_s = (cnt_nxt_s != {CNT_WIDTH{1'b0}}) | (state_nxt_s == S_OUT);
    end

    // Counter, latched length and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r       <= {CNT_WIDTH{1'b0}};
            len_q_r     <= {CNT_WIDTH{1'b0}};
            res_ready_r <= 1'b0;
            acc_val_r   <= 1'b0;
            busy_r      <= 1'b0;
            acc_data_r  <= {(2*ACC_WIDTH){1'b0}};
        end else begin
            cnt_r       <= cnt_nxt_s;
            len_q_r     <= len_q_nxt_s;
            res_ready_r <= res_ready_nxt_s;
            acc_val_r   <= acc_val_nxt_s;
            busy_r      <= busy_nxt_s;
            acc_data_r  <= acc_data_nxt_s;
        end
    end

    assign res_ready = res_ready_r;
    assign acc_val   = acc_val_r;
    assign acc_data  = acc_data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_complex_acc_stage.sv
// Directed bench for complex_acc_stage: hand-computed sums, back-pressure, resets.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_complex_acc_stage;

    logic        clk;
    logic        rstn;
    logic        sw_rst;
    logic [3:0]  acc_len;
    logic        res_val;
    logic        res_ready;
    logic [33:0] res_data;
    logic        acc_val;
    logic        acc_ready;
    logic [41:0] acc_data;
    logic        busy;

    int n_checks;
    int n_errors;

    complex_acc_stage dut (
        .clk       (clk),
        .rstn      (rstn),
        .sw_rst    (sw_rst),
        .acc_len   (acc_len),
        .res_val   (res_val),
        .res_ready (res_ready),
        .res_data  (res_data),
        .acc_val   (acc_val),
        .acc_ready (acc_ready),
        .acc_data  (acc_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [41:0] cpx(input int re, input int im);
        logic [31:0] r;
        logic [31:0] i;
        r = re;
        i = im;
        return {r[20:0], i[20:0]};
    endfunction

    // Called on a falling edge; returns on the falling edge after the beat is accepted
    task automatic send_beat(input int re, input int im);
        logic [31:0] r;
        logic [31:0] i;
        int n;
        n = 0;
        r = re;
        i = im;
        while (!res_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!res_ready) begin
            check_val("beat_timeout", 64'(res_ready), 64'd1);
        end
        res_val  = 1'b1;
        res_data = {r[16:0], i[16:0]};
        @(negedge clk);
        res_val  = 1'b0;
        res_data = 34'h2_AAAA_5555;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rstn      = 1'b0;
        sw_rst    = 1'b0;
        acc_len   = 4'd1;
        res_val   = 1'b0;
        res_data  = 34'd0;
        acc_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_res_ready", 64'(res_ready), 64'd0);
        check_val("rst_acc_val",   64'(acc_val),   64'd0);
        check_val("rst_acc_data",  64'(acc_data),  64'd0);
        check_val("rst_busy",      64'(busy),      64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check_val("idle_to_accum_ready", 64'(res_ready), 64'd1);

        // Single-beat sum
        acc_len = 4'd1;
        send_beat(5, -3);
        check_val("single_val",   64'(acc_val),   64'd1);
        check_val("single_data",  64'(acc_data),  64'(cpx(5, -3)));
        check_val("single_ready", 64'(res_ready), 64'd0);
        check_val("single_busy",  64'(busy),      64'd1);
        @(negedge clk);
        check_val("single_val_drop",   64'(acc_val),   64'd0);
        check_val("single_ready_back", 64'(res_ready), 64'd1);
        check_val("single_busy_drop",  64'(busy),      64'd0);

        // Three-beat sum with idle gaps; acc_len change mid-sum must be ignored
        acc_len   = 4'd3;
        acc_ready = 1'b0;
        send_beat(1, 2);
        acc_len = 4'd1;
        check_val("three_busy_b1", 64'(busy), 64'd1);
        repeat (2) @(negedge clk);
        check_val("three_busy_gap", 64'(busy),    64'd1);
        check_val("three_no_val",   64'(acc_val), 64'd0);
        send_beat(3, 4);
        check_val("three_no_val_b2", 64'(acc_val), 64'd0);
        repeat (2) @(negedge clk);
        send_beat(-10, 0);
        check_val("three_val",  64'(acc_val),  64'd1);
        check_val("three_data", 64'(acc_data), 64'(cpx(-6, 6)));
        check_val("three_busy", 64'(busy),     64'd1);
        acc_ready = 1'b1;
        @(negedge clk);
        check_val("three_val_drop",  64'(acc_val), 64'd0);
        check_val("three_busy_drop", 64'(busy),    64'd0);

        // Back-pressure: sum held while acc_ready low; waiting beat accepted afterwards
        acc_len   = 4'd2;
        acc_ready = 1'b0;
        send_beat(10, 20);
        send_beat(30, 40);
        acc_len  = 4'd1;
        res_val  = 1'b1;
        res_data = {17'd99, 17'd99};
        for (int k = 0; k < 5; k++) begin
            check_val("bp_val",   64'(acc_val),   64'd1);
            check_val("bp_data",  64'(acc_data),  64'(cpx(40, 60)));
            check_val("bp_ready", 64'(res_ready), 64'd0);
            @(negedge clk);
        end
        acc_ready = 1'b1;
        @(negedge clk);
        check_val("bp_release_val",   64'(acc_val),   64'd0);
        check_val("bp_release_ready", 64'(res_ready), 64'd1);
        check_val("bp_release_busy",  64'(busy),      64'd0);
        @(negedge clk);
        res_val = 1'b0;
        check_val("bp_resume_val",  64'(acc_val),  64'd1);
        check_val("bp_resume_data", 64'(acc_data), 64'(cpx(99, 99)));
        @(negedge clk);

        // Full-scale: 16 beats of (-65536, 65535)
        acc_len = 4'd0;
        for (int k = 0; k < 15; k++) begin
            send_beat(-65536, 65535);
        end
        check_val("fs_no_val_15", 64'(acc_val), 64'd0);
        send_beat(-65536, 65535);
        check_val("fs_val",  64'(acc_val),  64'd1);
        check_val("fs_data", 64'(acc_data), 64'(cpx(-1048576, 1048560)));
        @(negedge clk);

        // Software reset mid-sum discards the partial sum and the coincident beat
        acc_len = 4'd4;
        send_beat(7, 7);
        send_beat(7, 7);
        sw_rst   = 1'b1;
        res_val  = 1'b1;
        res_data = {17'd7, 17'd7};
        @(negedge clk);
        sw_rst  = 1'b0;
        res_val = 1'b0;
        check_val("swrst_busy",  64'(busy),      64'd0);
        check_val("swrst_ready", 64'(res_ready), 64'd1);
        check_val("swrst_val",   64'(acc_val),   64'd0);
        check_val("swrst_data",  64'(acc_data),  64'd0);
        for (int k = 0; k < 3; k++) begin
            send_beat(1, 1);
            check_val("swrst_no_val", 64'(acc_val), 64'd0);
        end
        send_beat(1, 1);
        check_val("swrst_sum_val",  64'(acc_val),  64'd1);
        check_val("swrst_sum_data", 64'(acc_data), 64'(cpx(4, 4)));
        @(negedge clk);

        // Asynchronous reset while a sum is presented
        acc_len   = 4'd1;
        acc_ready = 1'b0;
        send_beat(3, 3);
        check_val("arst_pre_val", 64'(acc_val), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_val("arst_val",   64'(acc_val),   64'd0);
        check_val("arst_data",  64'(acc_data),  64'd0);
        check_val("arst_ready", 64'(res_ready), 64'd0);
        check_val("arst_busy",  64'(busy),      64'd0);
        @(negedge clk);
        rstn = 1'b1;
        check_val("arst_held_ready", 64'(res_ready), 64'd0);
        @(negedge clk);
        check_val("arst_ready_back", 64'(res_ready), 64'd1);
        acc_len   = 4'd2;
        acc_ready = 1'b1;
        send_beat(2, -2);
        send_beat(3, -3);
        check_val("arst_new_val",  64'(acc_val),  64'd1);
        check_val("arst_new_data", 64'(acc_data), 64'(cpx(5, -5)));
        @(negedge clk);
        check_val("arst_new_drop", 64'(acc_val), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
